// File: rtl/memory_cycle_if.sv
// memory_cycle_if
//   Groups the M-stage inputs and W-stage outputs of the memory pipeline
//   stage into one bundle.
//   master : drives the M-stage controls/data, observes the W-stage results
//   slave  : the memory stage itself (consumes M, produces W)
//   M side : RegWriteM, MemWriteM, ResultSrcM, StallM, funct3M[2:0], RdM[4:0],
//            ALU_ResultM[31:0], WriteDataM[31:0], PCPlus4M[31:0]
//   W side : RegWriteW, ResultSrcW, RdW[4:0], ALU_ResultW[31:0],
//            ReadDataW[31:0], PCPlus4W[31:0], MisalignW
interface memory_cycle_if;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic        StallM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALU_ResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;

  logic        RegWriteW;
  logic        ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic        MisalignW;

  modport master (
    output RegWriteM, MemWriteM, ResultSrcM, StallM, funct3M, RdM,
           ALU_ResultM, WriteDataM, PCPlus4M,
    input  RegWriteW, ResultSrcW, RdW, ALU_ResultW, ReadDataW, PCPlus4W,
           MisalignW
  );

  modport slave (
    input  RegWriteM, MemWriteM, ResultSrcM, StallM, funct3M, RdM,
           ALU_ResultM, WriteDataM, PCPlus4M,
    output RegWriteW, ResultSrcW, RdW, ALU_ResultW, ReadDataW, PCPlus4W,
           MisalignW
  );
endinterface

// File: rtl/memory_cycle.sv
// memory_cycle
//   Memory stage of a 5-stage RISC-V pipeline: a DEPTH x 32-bit data memory
//   with byte/halfword/word stores and sign/zero-extending loads, followed by
//   the M->W pipeline register.
//   Ports:
//     clk : clock, all state changes on the rising edge
//     rst : synchronous, active-high; clears the W register (not the memory)
//     bus : memory_cycle_if.slave -- M-stage inputs, registered W outputs
//   Loads read the addressed word combinationally, so a load and a store to
//   the same word in one cycle see the old contents (read-before-write).
//   Misaligned accesses never write memory, read as zero and suppress the
//   register write in W.
module memory_cycle #(
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  memory_cycle_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  // Size encoding in funct3[1:0]: 00 byte, 01 halfword, anything else word
  // (this folds the unsupported 011/110/111 codes onto LW/SW).
  function automatic logic isMisaligned(input logic [2:0] f3,
                                        input logic [1:0] lo);
    logic mis;
    unique case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [31:0] formatLoad(input logic [2:0]  f3,
                                             input logic [1:0]  lo,
                                             input logic [31:0] word);
    logic signed [7:0]  sByte;
    logic signed [15:0] sHalf;
    logic signed [31:0] ext;
    logic        [31:0] res;
    sByte = word[8*lo +: 8];
    sHalf = lo[1] ? word[31:16] : word[15:0];
    ext   = '0;
    unique case (f3)
      3'b000: begin
        ext = 32'(sByte);
        res = ext;
      end
      3'b001: begin
        ext = 32'(sHalf);
        res = ext;
      end
      3'b100:  res = {24'h0, sByte};
      3'b101:  res = {16'h0, sHalf};
      default: res = word;
    endcase
    return res;
  endfunction

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] wordIdx_p0;
  logic [1:0]    byteOff_p0;
  logic          misaligned_p0;
  logic          accessMisaligned_p0;
  logic [31:0]   readWord_p0;
  logic [31:0]   readData_p0;
  logic [3:0]    byteEn_p0;
  logic [31:0]   storeData_p0;
  logic          storeEn_p0;
  logic          unusedAddrBits;

  // ---- M stage: address decode, read formatting, store lane selection ----
  assign wordIdx_p0     = bus.ALU_ResultM[AW+1:2];
  assign byteOff_p0     = bus.ALU_ResultM[1:0];
  assign unusedAddrBits = ^bus.ALU_ResultM[31:AW+2];

  assign misaligned_p0       = isMisaligned(bus.funct3M, byteOff_p0);
  assign accessMisaligned_p0 = (bus.MemWriteM | bus.ResultSrcM) & misaligned_p0;

  assign readWord_p0 = mem[wordIdx_p0];
  assign readData_p0 = misaligned_p0 ? 32'h0
                                     : formatLoad(bus.funct3M, byteOff_p0, readWord_p0);

  always_comb begin
    byteEn_p0    = 4'b1111;
    storeData_p0 = bus.WriteDataM;
    unique case (bus.funct3M[1:0])
      2'b00: begin
        byteEn_p0    = 4'b0001 << byteOff_p0;
        storeData_p0 = {4{bus.WriteDataM[7:0]}};
      end
      2'b01: begin
        byteEn_p0    = byteOff_p0[1] ? 4'b1100 : 4'b0011;
        storeData_p0 = {2{bus.WriteDataM[15:0]}};
      end
      default: begin
        byteEn_p0    = 4'b1111;
        storeData_p0 = bus.WriteDataM;
      end
    endcase
  end

  assign storeEn_p0 = bus.MemWriteM & ~bus.StallM & ~rst & ~misaligned_p0;

  // Data memory has no reset; contents stay undefined until written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (storeEn_p0 && byteEn_p0[i]) begin
        mem[wordIdx_p0][8*i +: 8] <= storeData_p0[8*i +: 8];
      end
    end
  end

  // ---- M -> W pipeline register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.RegWriteW   <= 1'b0;
      bus.ResultSrcW  <= 1'b0;
      bus.RdW         <= 5'd0;
      bus.ALU_ResultW <= 32'h0;
      bus.ReadDataW   <= 32'h0;
      bus.PCPlus4W    <= 32'h0;
      bus.MisalignW   <= 1'b0;
    end else if (!bus.StallM) begin
      bus.RegWriteW   <= bus.RegWriteM & ~accessMisaligned_p0;
      bus.ResultSrcW  <= bus.ResultSrcM;
      bus.RdW         <= bus.RdM;
      bus.ALU_ResultW <= bus.ALU_ResultM;
      bus.ReadDataW   <= readData_p0;
      bus.PCPlus4W    <= bus.PCPlus4M;
      bus.MisalignW   <= accessMisaligned_p0;
    end
  end

endmodule
